// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port main memory between the fetch unit and
// the load/store unit. Requests are serialised, every memory strobe is decoded
// from the FSM state, and d_bus is driven only while a write is in progress.
//
// Requester handshake: req is raised with addr/we/wdata valid and held until
// the matching ack pulses for one cycle. addr/we/wdata are captured at grant,
// so later changes are ignored. Dropping req after grant does not abort the
// access. A port whose ack is high is not eligible, so a req still high in the
// ack cycle is not re-granted by mistake.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              i_read,
  output logic              i_push,
  output logic              d_read,
  output logic              d_push,
  output logic              d_write,
  output logic [ADDR_W-1:0] i_addr,
  output logic [ADDR_W-1:0] d_addr,
  inout  wire  [DATA_W-1:0] d_bus,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] I_RD   = 3'd1;
  localparam logic [2:0] I_PUSH = 3'd2;
  localparam logic [2:0] D_RD   = 3'd3;
  localparam logic [2:0] D_PUSH = 3'd4;
  localparam logic [2:0] D_WR   = 3'd5;

  localparam logic LG_FETCH = 1'b0;
  localparam logic LG_DATA  = 1'b1;

  logic [2:0]        state;
  logic              last_grant;
  logic [DATA_W-1:0] wdata;
  logic              if_elig;
  logic              dm_elig;
  logic              grant_if;
  logic              grant_dm;

  // Eligibility and round-robin tie break; only acted on in IDLE.
  always_comb begin
    if_elig  = if_req && !if_ack;
    dm_elig  = dm_req && !dm_ack;
    grant_if = if_elig && (!dm_elig || (last_grant == LG_DATA));
    grant_dm = dm_elig && !grant_if;
  end

  // Moore strobe decode; reset forces IDLE so strobes drop asynchronously.
  always_comb begin
    i_read    = (state == I_RD);
    i_push    = (state == I_PUSH);
    d_read    = (state == D_RD);
    d_push    = (state == D_PUSH);
    d_write   = (state == D_WR);
    dbg_state = state;
  end

  // The bus is ours only during a write; the memory owns it during pushes.
  assign d_bus = (state == D_WR) ? wdata : {DATA_W{1'bz}};

  // Sequencer: grant in IDLE, step through the access, capture data and ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= LG_DATA;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_data    <= '0;
      dm_rdata   <= '0;
      i_addr     <= '0;
      d_addr     <= '0;
      wdata      <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            i_addr     <= if_addr;
            last_grant <= LG_FETCH;
            state      <= I_RD;
          end else if (grant_dm) begin
            d_addr     <= dm_addr;
            last_grant <= LG_DATA;
            if (dm_we) begin
              wdata <= dm_wdata;
              state <= D_WR;
            end else begin
              state <= D_RD;
            end
          end
        end
        I_RD:   state <= I_PUSH;
        I_PUSH: begin
          if_data <= d_bus;
          if_ack  <= 1'b1;
          state   <= IDLE;
        end
        D_RD:   state <= D_PUSH;
        D_PUSH: begin
          dm_rdata <= d_bus;
          dm_ack   <= 1'b1;
          state    <= IDLE;
        end
        D_WR: begin
          dm_ack <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized requesters, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          if_ack, dm_ack, i_read, i_push, d_read, d_push, d_write;
  logic [DW-1:0] if_data, dm_rdata;
  logic [AW-1:0] i_addr, d_addr;
  logic [2:0]    dbg_state;
  wire  [DW-1:0] d_bus;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .i_read(i_read), .i_push(i_push), .d_read(d_read), .d_push(d_push),
    .d_write(d_write), .i_addr(i_addr), .d_addr(d_addr), .d_bus(d_bus),
    .dbg_state(dbg_state)
  );

  // ---------------- main memory model ----------------
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ref_mem [0:255];
  assign d_bus = i_push ? mem[i_addr[7:0]] : (d_push ? mem[d_addr[7:0]] : {DW{1'bz}});
  always @(posedge clk) if (d_write) mem[d_addr[7:0]] <= d_bus;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  // A transaction is a kind plus the number of cycles it has been running.
  // Fetch and data read occupy two cycles, a write occupies one.
  localparam int K_FETCH = 0, K_READ = 1, K_WRITE = 2;
  bit            m_busy;
  int            m_kind, m_age;
  bit            m_last_data;
  bit            m_if_ack, m_dm_ack;
  logic [DW-1:0] m_if_data, m_dm_rdata, m_wdata;
  logic [AW-1:0] m_i_addr, m_d_addr;
  int            m_grants[$];

  function automatic int txn_len(input int k);
    return (k == K_WRITE) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_kind = 0; m_age = 0; m_last_data = 1;
    m_if_ack = 0; m_dm_ack = 0; m_if_data = '0; m_dm_rdata = '0;
    m_wdata = '0; m_i_addr = '0; m_d_addr = '0;
  endtask

  task automatic model_step();
    bit new_if_ack, new_dm_ack, fe, de;
    new_if_ack = 0; new_dm_ack = 0;
    if (m_busy) begin
      m_age++;
      if (m_age == txn_len(m_kind)) begin
        m_busy = 0;
        if (m_kind == K_FETCH) begin
          m_if_data = ref_mem[m_i_addr[7:0]]; new_if_ack = 1;
        end else if (m_kind == K_READ) begin
          m_dm_rdata = ref_mem[m_d_addr[7:0]]; new_dm_ack = 1;
        end else begin
          ref_mem[m_d_addr[7:0]] = m_wdata; new_dm_ack = 1;
        end
      end
    end else begin
      fe = if_req && !m_if_ack;
      de = dm_req && !m_dm_ack;
      if (fe && (!de || m_last_data)) begin
        m_busy = 1; m_age = 0; m_kind = K_FETCH; m_i_addr = if_addr; m_last_data = 0;
        m_grants.push_back(K_FETCH);
      end else if (de) begin
        m_busy = 1; m_age = 0; m_d_addr = dm_addr; m_last_data = 1;
        m_kind = dm_we ? K_WRITE : K_READ;
        if (dm_we) m_wdata = dm_wdata;
        m_grants.push_back(m_kind);
      end
    end
    m_if_ack = new_if_ack;
    m_dm_ack = new_dm_ack;
  endtask

  task automatic check_all();
    bit e_ir, e_ip, e_dr, e_dp, e_dw;
    e_ir = m_busy && m_kind == K_FETCH && m_age == 0;
    e_ip = m_busy && m_kind == K_FETCH && m_age == 1;
    e_dr = m_busy && m_kind == K_READ  && m_age == 0;
    e_dp = m_busy && m_kind == K_READ  && m_age == 1;
    e_dw = m_busy && m_kind == K_WRITE;
    check("strobes", {27'd0, i_read, i_push, d_read, d_push, d_write},
          {27'd0, e_ir, e_ip, e_dr, e_dp, e_dw});
    check("onehot", 32'($countones({i_read, i_push, d_read, d_push, d_write}) <= 1), 32'd1);
    check("acks", {30'd0, if_ack, dm_ack}, {30'd0, m_if_ack, m_dm_ack});
    check("if_data", 32'(if_data), 32'(m_if_data));
    check("dm_rdata", 32'(dm_rdata), 32'(m_dm_rdata));
    check("i_addr", 32'(i_addr), 32'(m_i_addr));
    check("d_addr", 32'(d_addr), 32'(m_d_addr));
    if (e_dw) check("wr_bus", 32'(d_bus), 32'(m_wdata));
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_dm_ack(input string tag);
    int n;
    n = 0;
    while (!dm_ack && n < 8) begin cycle(); n++; end
    check(tag, 32'(dm_ack), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16] = 16'hA000; ref_mem[16] = 16'hA000;
    model_reset();
    #12;
    check("rst_strobes", {27'd0, i_read, i_push, d_read, d_push, d_write}, 32'd0);
    check("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
    check("rst_regs", {if_data, dm_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch of address 16.
    if_req = 1; if_addr = 16;
    cycle();
    check("fetch_iread", 32'(i_read), 32'd1);
    cycle();
    check("fetch_push_bus", 32'(d_bus), 32'hA000);
    cycle();
    check("fetch_ack", 32'(if_ack), 32'd1);
    check("fetch_data", 32'(if_data), 32'hA000);
    if_req = 0;
    cycle();

    // Write 64, then disturb inputs and drop req after grant.
    dm_req = 1; dm_we = 1; dm_addr = 64; dm_wdata = 16'h1234;
    cycle();
    check("wr_dwrite", 32'(d_write), 32'd1);
    check("wr_dbus", 32'(d_bus), 32'h1234);
    dm_addr = 16'h55; dm_wdata = 16'hBEEF; dm_req = 0;
    cycle();
    check("wr_ack", 32'(dm_ack), 32'd1);
    check("wr_mem", 32'(mem[64]), 32'h1234);
    check("wr_mem_untouched", 32'(mem[16'h55]), 32'(ref_mem[16'h55]));

    // Read 64 back; req held through the write's ack cycle.
    dm_req = 1; dm_we = 0; dm_addr = 64;
    cycle();
    check("no_regrant_in_ack", 32'(d_read), 32'd0);
    wait_dm_ack("rd_ack");
    check("rd_data", 32'(dm_rdata), 32'h1234);
    dm_req = 0;
    cycle(); cycle();

    // Both ports requesting continuously: grants must alternate.
    m_grants.delete();
    if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 3; if_addr = 5;
    repeat (14) cycle();
    if_req = 0; dm_req = 0;
    repeat (4) cycle();
    check("tie_grants", 32'(m_grants.size() >= 4), 32'd1);

    // Reset in the middle of a write.
    dm_req = 1; dm_we = 1; dm_addr = 70; dm_wdata = 16'h7777;
    cycle();
    check("pre_rst_dwrite", 32'(d_write), 32'd1);
    rst_n = 0; dm_req = 0;
    #1;
    check("async_dwrite", 32'(d_write), 32'd0);
    check("async_ack", 32'(dm_ack), 32'd0);
    model_reset();
    cycle();
    rst_n = 1;
    cycle();
    check("rst_no_write", 32'(mem[70]), 32'(ref_mem[70]));
    if_req = 1; if_addr = 9; dm_req = 1; dm_we = 0; dm_addr = 10;
    cycle();
    check("post_rst_tie_fetch", 32'(i_read), 32'd1);
    if_req = 0; dm_req = 0;
    repeat (8) cycle();

    // Randomized requesters; addr/data scrambled while req is held.
    for (int c = 0; c < 600; c++) begin
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = 16'($urandom_range(0, 31)); end
      end else begin
        if (m_if_ack) begin if ($urandom_range(0, 3) != 0) if_req = 0; end
        else if ($urandom_range(0, 15) == 0) if_req = 0;
        if_addr = 16'($urandom_range(0, 31));
      end
      if (!dm_req) begin
        if ($urandom_range(0, 2) == 0) begin
          dm_req = 1; dm_we = 1'($urandom_range(0, 1));
          dm_addr = 16'($urandom_range(0, 31)); dm_wdata = 16'($urandom);
        end
      end else begin
        if (m_dm_ack) begin if ($urandom_range(0, 3) != 0) dm_req = 0; end
        else if ($urandom_range(0, 15) == 0) dm_req = 0;
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = 16'($urandom_range(0, 31)); dm_wdata = 16'($urandom);
      end
      cycle();
    end
    if_req = 0; dm_req = 0;
    repeat (5) cycle();
    for (int i = 0; i < 32; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Alternation monitor for the continuous-tie window.
  always @(negedge clk) begin
    if (m_grants.size() >= 2 && if_req && dm_req && !dm_we && rst_n) begin
      if (m_grants[m_grants.size()-1] == m_grants[m_grants.size()-2] &&
          m_grants.size() <= 8 && m_grants[0] != K_WRITE)
        check("tie_alternate", 32'(m_grants[m_grants.size()-1]), 32'(1 - m_grants[m_grants.size()-2]));
    end
  end

endmodule
